uart_program_loader: RTL and testbench
======================================

Name: uart_program_loader

Overview:
Front-end boot stage that sits upstream of the CPU core and instruction memory. It receives the program image over a serial UART line (8N1) and assembles little-endian 32-bit words. It writes those words sequentially into instruction memory cells 0..CELL_NUMBERS-1. It holds the CPU stalled until the last cell is written, then releases it for instruction fetch.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit; must be >= 4.
CELL_NUMBERS, 64, number of 32-bit words to load before releasing the CPU.
ADDR_WIDTH, 6, width of mem_addr; must satisfy 2**ADDR_WIDTH >= CELL_NUMBERS.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset asserted).
uart_rx  input  1  serial receive line; idles high; asynchronous to clk.
mem_we  output  1  one-cycle write strobe to instruction memory.
mem_addr  output  ADDR_WIDTH  word index being written.
mem_wdata  output  32  assembled word.
cpu_hold  output  1  1 = CPU stalled (PC frozen, no fetch); 0 = CPU runs.
load_done  output  1  1 once all CELL_NUMBERS words have been written; sticky.
frame_err  output  1  one-cycle pulse when the stop bit samples 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, frame_err=0, cpu_hold=1.
  - Byte counter, word index, bit counter and baud counter all 0; state IDLE.
  - Reset asserted mid-frame or mid-load abandons all progress; the next load restarts at cell 0.
- uart_rx passes through a 2-flop synchroniser (preset to 1 on reset). All decisions use the synchronised value.
- States:
  - IDLE: waits for synchronised rx=0, then goes to START with baud counter cleared.
  - START: at count CLKS_PER_BIT/2-1 (bit centre), samples rx.
    - rx=1: false start; return to IDLE.
    - rx=0: go to DATA with bit counter=0.
  - DATA: samples every CLKS_PER_BIT cycles after the start-bit centre.
    - 8 bits, LSB first, shifted into the byte register.
    - After bit 7, go to STOP.
  - STOP: samples rx one CLKS_PER_BIT later.
    - rx=1: byte accepted.
      - Byte k (k = byte counter 0..3) is placed in wdata[8k+7:8k].
      - If k<3: byte counter increments; go to IDLE.
      - If k=3: go to WRITE.
    - rx=0: frame_err pulses for exactly that cycle; the byte is discarded; byte counter unchanged; go to IDLE.
  - WRITE: single cycle.
    - mem_we=1 with mem_addr=word index and mem_wdata=assembled word. This is the cycle immediately after the 4th stop-bit sample.
    - Byte counter resets to 0.
    - If word index = CELL_NUMBERS-1: go to DONE. Otherwise word index increments and the state returns to IDLE.
  - DONE:
    - load_done=1 and cpu_hold=0, both registered; they change the cycle after the final WRITE cycle.
    - All further rx activity is ignored, so there is no rewrite.
    - Exit only via reset.
- mem_addr and mem_wdata are valid only while mem_we=1. They hold their last values otherwise.
- The address never wraps: a write to CELL_NUMBERS-1 is terminal.
- A partial word (1–3 bytes) never produces a write and leaves cpu_hold=1 indefinitely.
- frame_err and mem_we are never asserted in the same cycle.

Test Plan:
- Reset values (CLKS_PER_BIT=4, CELL_NUMBERS=4): hold rst=0, toggle uart_rx -> cpu_hold=1, load_done=0, mem_we=0, mem_addr=0.
- Single word: send bytes 0x93,0x80,0x80,0x00 -> exactly one mem_we pulse, mem_addr=0, mem_wdata=0x00808093; cpu_hold stays 1.
- Full load: send 4 words 0x00700093, 0x00800113, 0xFFF00193, 0x00808093 -> writes at addr 0..3 in order; load_done=1 and cpu_hold=0 one cycle after the 4th mem_we; 5th word sent afterwards -> no mem_we.
- Frame error: send 0x11, then 0x22 with stop bit=0, then 0x33,0x44,0x55 -> one frame_err pulse; written word = 0x55443311.
- Glitch: drive rx low for 1 cycle (shorter than CLKS_PER_BIT/2) -> no byte accepted, byte counter unchanged.
- Reset mid-load: after 2 words, pulse rst=0 in the middle of a byte; then send 4 words -> writes restart at addr 0; load_done only after 4 new writes.

Source files
------------

// File: rtl/uart_program_loader.sv
// UART (8N1) boot loader: receives a program image byte by byte, packs
// little-endian 32-bit words and writes them to instruction memory cells
// 0..CELL_NUMBERS-1. The CPU is held until the last cell has been written.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CELL_NUMBERS = 64,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  frame_err
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0]     HALF_M1   = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0]     FULL_M1   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(CELL_NUMBERS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WRITE, DONE} state_t;

    state_t                state_q;
    logic                  rx_meta_q, rx_sync_q;
    logic [BAUD_W-1:0]     baud_q;
    logic [2:0]            bit_cnt_q;
    logic [1:0]            byte_cnt_q;
    logic [ADDR_WIDTH-1:0] word_idx_q;
    logic [7:0]            shift_q;
    logic [23:0]           word_q;
    logic                  mem_we_q, cpu_hold_q, load_done_q, frame_err_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;

    logic [7:0]            shift_d;
    logic [31:0]           word_d;

    // Next values of the byte shifter (LSB first) and of the full word once byte 3 lands
    assign shift_d = {rx_sync_q, shift_q[7:1]};
    assign word_d  = {shift_q, word_q};

    // Two-flop synchroniser for the asynchronous rx line; idles high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver / loader FSM with registered memory and CPU-control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            word_idx_q  <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            mem_we_q    <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_sync_q) begin
                        state_q <= START;
                        baud_q  <= '0;
                    end
                end
                START: begin
                    if (baud_q == HALF_M1) begin
                        baud_q <= '0;
                        if (rx_sync_q) begin
                            state_q <= IDLE;
                        end else begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_q == FULL_M1) begin
                        baud_q  <= '0;
                        shift_q <= shift_d;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_q == FULL_M1) begin
                        baud_q <= '0;
                        if (!rx_sync_q) begin
                            // Bad stop bit: drop the byte, keep the byte position
                            frame_err_q <= 1'b1;
                            state_q     <= IDLE;
                        end else if (byte_cnt_q == 2'd3) begin
                            // Strobe is raised now so it is visible during WRITE
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= word_idx_q;
                            mem_wdata_q <= word_d;
                            state_q     <= WRITE;
                        end else begin
                            case (byte_cnt_q)
                                2'd0:    word_q[7:0]   <= shift_q;
                                2'd1:    word_q[15:8]  <= shift_q;
                                default: word_q[23:16] <= shift_q;
                            endcase
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            state_q    <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                WRITE: begin
                    byte_cnt_q <= '0;
                    if (word_idx_q == LAST_CELL) begin
                        state_q     <= DONE;
                        load_done_q <= 1'b1;
                        cpu_hold_q  <= 1'b0;
                    end else begin
                        word_idx_q <= word_idx_q + 1'b1;
                        state_q    <= IDLE;
                    end
                end
                // Terminal: rx is ignored until reset
                DONE:    state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with a write scoreboard.
module tb_uart_program_loader;

    localparam int CPB   = 4;
    localparam int CELLS = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          uart_rx = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold, load_done, frame_err;

    int tests = 0;
    int fails = 0;
    int fe_cnt = 0;
    int wr_cnt = 0;
    bit chk_done_next = 0;
    logic [AW+31:0] sb[$];

    uart_program_loader #(.CLKS_PER_BIT(CPB), .CELL_NUMBERS(CELLS), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write and checks release timing
    always @(negedge clk) begin
        if (!rst) begin
            wr_cnt = 0;
            chk_done_next = 0;
        end else begin
            if (chk_done_next) begin
                chk("release_after_last_write", {62'd0, load_done, cpu_hold}, 64'b10);
                chk_done_next = 0;
            end
            if (mem_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", {30'd0, mem_addr, mem_wdata}, 64'hDEAD);
                end else begin
                    chk("write_addr_data", {30'd0, mem_addr, mem_wdata}, {30'd0, sb.pop_front()});
                end
                chk("hold_during_write", {62'd0, load_done, cpu_hold}, 64'b01);
                chk("no_fe_with_we", {63'd0, frame_err}, 64'd0);
                wr_cnt++;
                if (wr_cnt == CELLS) chk_done_next = 1;
            end
            if (frame_err) fe_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    logic [31:0] words [4] = '{32'h00700093, 32'h00800113, 32'hFFF00193, 32'h00808093};

    initial begin
        // Reset values while rx toggles
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) uart_rx = i[0];
        end
        uart_rx = 1'b1;
        chk("rst_outputs", {29'd0, cpu_hold, load_done, mem_we, frame_err, mem_addr},
            {29'd0, 1'b1, 1'b0, 1'b0, 1'b0, {AW{1'b0}}});
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single word
        sb.push_back({2'd0, 32'h00808093});
        send_word(32'h00808093);
        repeat (4) @(negedge clk);
        chk("single_sb_empty", 64'(sb.size()), 64'd0);
        chk("single_hold", {62'd0, load_done, cpu_hold}, 64'b01);
        chk("single_wcnt", 64'(wr_cnt), 64'd1);

        // Full load, then extra word is ignored
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back({AW'(i), words[i]});
            send_word(words[i]);
        end
        repeat (4) @(negedge clk);
        chk("full_sb_empty", 64'(sb.size()), 64'd0);
        chk("full_done", {62'd0, load_done, cpu_hold}, 64'b10);
        send_word(32'h12345678);
        repeat (4) @(negedge clk);
        chk("extra_no_write", 64'(wr_cnt), 64'd4);
        chk("done_sticky", {62'd0, load_done, cpu_hold}, 64'b10);

        // Frame error drops one byte
        do_reset();
        fe_cnt = 0;
        sb.push_back({2'd0, 32'h55443311});
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        chk("fe_count", 64'(fe_cnt), 64'd1);
        chk("fe_sb_empty", 64'(sb.size()), 64'd0);

        // Short glitch between bytes of the next word
        sb.push_back({2'd1, 32'hA5C3_0F81});
        send_byte(8'h81, 1'b1);
        send_byte(8'h0F, 1'b1);
        @(negedge clk) uart_rx = 1'b0;
        @(negedge clk) uart_rx = 1'b1;
        repeat (8) @(negedge clk);
        chk("glitch_no_fe", 64'(fe_cnt), 64'd1);
        send_byte(8'hC3, 1'b1);
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        chk("glitch_sb_empty", 64'(sb.size()), 64'd0);
        chk("glitch_wcnt", 64'(wr_cnt), 64'd2);

        // Reset in the middle of a byte after two words
        do_reset();
        for (int i = 0; i < 2; i++) begin
            sb.push_back({AW'(i), words[i]});
            send_word(words[i]);
        end
        @(negedge clk) uart_rx = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        uart_rx = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_state", {61'd0, cpu_hold, load_done, mem_we}, 64'b100);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_sb_empty", 64'(sb.size()), 64'd0);
        for (int i = 0; i < 4; i++) begin
            sb.push_back({AW'(i), words[3 - i]});
            send_word(words[3 - i]);
            if (i < 3) chk("midrst_not_done", {62'd0, load_done, cpu_hold}, 64'b01);
        end
        repeat (4) @(negedge clk);
        chk("midrst_final_sb", 64'(sb.size()), 64'd0);
        chk("midrst_done", {62'd0, load_done, cpu_hold}, 64'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
